// File: rtl/diffeq_pkg.sv
// diffeq_pkg
// Shared definitions for the differential-equation solver controller and
// datapath: the 3-bit state codes (the datapath decodes the same values),
// the order in which operand nibbles arrive, and default loop/watchdog limits.
package diffeq_pkg;

    // State codes are driven straight onto the datapath's state input, so the
    // encoding is fixed. 3'b111 is unused and treated as illegal.
    typedef enum logic [2:0] {
        S_IDLE      = 3'b000,
        S_READ      = 3'b001,
        S_COMPUTE_1 = 3'b010,
        S_COMPUTE_2 = 3'b011,
        S_COMPUTE_3 = 3'b100,
        S_COMPUTE_4 = 3'b101,
        S_DONE      = 3'b110
    } state_t;

    // Operand nibbles arrive serially in this order.
    localparam int IDX_X       = 0;
    localparam int IDX_DX      = 1;
    localparam int IDX_A       = 2;
    localparam int IDX_U       = 3;
    localparam int NUM_NIBBLES = 4;

    localparam int DEFAULT_MAX_ITER     = 16;
    localparam int DEFAULT_STEP_TIMEOUT = 8;

endpackage

// File: rtl/diffeq_step_timer.sv
// diffeq_step_timer
// Per-step watchdog counter for the COMPUTE states.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   clear    : restart the count at 0 on the next edge (has priority)
//   enable   : count one cycle spent waiting
//   expired  : this is the STEP_TIMEOUT-th cycle spent waiting
module diffeq_step_timer
    import diffeq_pkg::*;
#(
    parameter int STEP_TIMEOUT = DEFAULT_STEP_TIMEOUT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(STEP_TIMEOUT + 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // count_reg holds the number of cycles already spent in the current step,
    // so it is 0 in the first cycle of a step. Flagging STEP_TIMEOUT-1 means
    // the count would reach STEP_TIMEOUT at the coming edge; the controller
    // leaves the step on that same edge.
    assign expired = (count_reg == CNT_W'(STEP_TIMEOUT - 1));

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count_reg != CNT_W'(STEP_TIMEOUT))) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/diffeq_controller.sv
// diffeq_controller
// Sequencing FSM for the differential-equation solver datapath. Collects the
// four serial operand nibbles (x, dx, a, u), issues one-hot load strobes with
// the forwarded nibble, walks the datapath through COMPUTE_1..COMPUTE_4 per
// iteration, and reports completion with a done/ack handshake.
//   clk, reset_n        : clock (rising edge), asynchronous active-low reset
//   start, abort        : begin a run (IDLE only) / return to IDLE from anywhere
//   in_valid, din       : serial operand nibble stream (used in READ only)
//   step_done           : datapath finished the current COMPUTE step
//   continue_while      : datapath loop condition, sampled with step_done in COMPUTE_4
//   ack                 : host acknowledges done
//   dp_in, load_*       : registered nibble and its one-cycle load strobe
//   state, busy, done   : current state code and its decodes
//   iter_count          : completed iterations (saturates at MAX_ITER)
//   iter_limit, step_err: run ended by the iteration cap / by the watchdog
// Every output is a register or a decode of the state register.
module diffeq_controller
    import diffeq_pkg::*;
#(
    parameter int MAX_ITER     = DEFAULT_MAX_ITER,
    parameter int ITER_W       = 5,
    parameter int STEP_TIMEOUT = DEFAULT_STEP_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [3:0]        din,
    input  logic              step_done,
    input  logic              continue_while,
    input  logic              ack,
    output logic [3:0]        dp_in,
    output logic              load_x,
    output logic              load_dx,
    output logic              load_a,
    output logic              load_u,
    output logic [2:0]        state,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] iter_count,
    output logic              iter_limit,
    output logic              step_err
);

    state_t              state_reg, state_next;
    // Nibble index 0..3 selects the next strobe; 4 means all operands are in.
    logic [2:0]          idx_reg, idx_next;
    logic [3:0]          dp_in_reg, dp_in_next;
    logic [3:0]          load_reg;
    logic [ITER_W-1:0]   iter_reg, iter_next;
    logic                limit_reg, limit_next;
    logic                err_reg, err_next;

    logic                accept;
    logic [3:0]          strobe_sel;
    logic [ITER_W-1:0]   iter_inc;
    logic                in_compute;
    logic                tmr_clear;
    logic                tmr_expired;

    // A nibble is taken only in READ, only until all four are in, and never in
    // the cycle abort wins; the strobe it produces appears one cycle later.
    assign accept = (state_reg == S_READ) && in_valid && !abort
                    && (idx_reg < 3'(NUM_NIBBLES));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_NIBBLES; gi++) begin : g_strobe
            assign strobe_sel[gi] = accept && (idx_reg == 3'(gi));
        end
    endgenerate

    assign iter_inc = (iter_reg == ITER_W'(MAX_ITER)) ? iter_reg : iter_reg + 1'b1;

    assign in_compute = (state_reg == S_COMPUTE_1) || (state_reg == S_COMPUTE_2) ||
                        (state_reg == S_COMPUTE_3) || (state_reg == S_COMPUTE_4);

    // Any state change restarts the watchdog, so every COMPUTE step (including
    // COMPUTE_4 -> COMPUTE_1) begins counting from 0.
    assign tmr_clear = (state_next != state_reg);

    diffeq_step_timer #(
        .STEP_TIMEOUT (STEP_TIMEOUT)
    ) u_step_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (tmr_clear),
        .enable  (in_compute),
        .expired (tmr_expired)
    );

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        dp_in_next = dp_in_reg;
        iter_next  = iter_reg;
        limit_next = limit_reg;
        err_next   = err_reg;

        if (abort) begin
            // Flags and iter_count are left as they are.
            state_next = S_IDLE;
            idx_next   = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_next = S_READ;
                        idx_next   = '0;
                        iter_next  = '0;
                        limit_next = 1'b0;
                        err_next   = 1'b0;
                    end
                end
                S_READ: begin
                    // Leaving only once idx reaches 4 keeps COMPUTE_1 one cycle
                    // behind load_u instead of overlapping it.
                    if (idx_reg == 3'(NUM_NIBBLES)) begin
                        state_next = S_COMPUTE_1;
                    end else if (accept) begin
                        dp_in_next = din;
                        idx_next   = idx_reg + 1'b1;
                    end
                end
                S_COMPUTE_1, S_COMPUTE_2, S_COMPUTE_3: begin
                    if (step_done) begin
                        case (state_reg)
                            S_COMPUTE_1: state_next = S_COMPUTE_2;
                            S_COMPUTE_2: state_next = S_COMPUTE_3;
                            default:     state_next = S_COMPUTE_4;
                        endcase
                    end else if (tmr_expired) begin
                        err_next   = 1'b1;
                        state_next = S_DONE;
                    end
                end
                S_COMPUTE_4: begin
                    if (step_done) begin
                        iter_next = iter_inc;
                        if (continue_while && (iter_inc < ITER_W'(MAX_ITER))) begin
                            state_next = S_COMPUTE_1;
                        end else begin
                            // Still wanting to loop here means the cap ended the run.
                            limit_next = continue_while;
                            state_next = S_DONE;
                        end
                    end else if (tmr_expired) begin
                        err_next   = 1'b1;
                        state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        state_next = S_IDLE;
                    end
                end
                default: begin
                    // Unused code 3'b111 falls back to IDLE.
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            idx_reg   <= '0;
            dp_in_reg <= '0;
            load_reg  <= '0;
            iter_reg  <= '0;
            limit_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            dp_in_reg <= dp_in_next;
            load_reg  <= strobe_sel;
            iter_reg  <= iter_next;
            limit_reg <= limit_next;
            err_reg   <= err_next;
        end
    end

    assign dp_in      = dp_in_reg;
    assign load_x     = load_reg[IDX_X];
    assign load_dx    = load_reg[IDX_DX];
    assign load_a     = load_reg[IDX_A];
    assign load_u     = load_reg[IDX_U];
    assign state      = state_reg;
    assign busy       = (state_reg != S_IDLE);
    assign done       = (state_reg == S_DONE);
    assign iter_count = iter_reg;
    assign iter_limit = limit_reg;
    assign step_err   = err_reg;

endmodule

// File: tb/tb_diffeq_controller.sv
// tb_diffeq_controller
// Drives two controllers from the same inputs (default cap 16 and cap 3),
// checks every cycle against a behavioural model, and pins the model with
// hand-computed expectations for the directed scenarios.
module tb_diffeq_controller;

    localparam int TO    = 8;
    localparam int MAX_A = 16;
    localparam int MAX_B = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start, abort, in_valid, step_done, continue_while, ack;
    logic [3:0] din;

    logic [3:0] dp_in_a, dp_in_b;
    logic       load_x_a, load_dx_a, load_a_a, load_u_a;
    logic       load_x_b, load_dx_b, load_a_b, load_u_b;
    logic [2:0] state_a, state_b;
    logic       busy_a, busy_b, done_a, done_b;
    logic [4:0] iter_count_a, iter_count_b;
    logic       iter_limit_a, iter_limit_b, step_err_a, step_err_b;

    logic [3:0]  strobes_a, strobes_b;
    logic [19:0] out_a, out_b;

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    diffeq_controller #(.MAX_ITER(MAX_A), .ITER_W(5), .STEP_TIMEOUT(TO)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .in_valid(in_valid), .din(din), .step_done(step_done),
        .continue_while(continue_while), .ack(ack), .dp_in(dp_in_a),
        .load_x(load_x_a), .load_dx(load_dx_a), .load_a(load_a_a), .load_u(load_u_a),
        .state(state_a), .busy(busy_a), .done(done_a), .iter_count(iter_count_a),
        .iter_limit(iter_limit_a), .step_err(step_err_a)
    );

    diffeq_controller #(.MAX_ITER(MAX_B), .ITER_W(5), .STEP_TIMEOUT(TO)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .in_valid(in_valid), .din(din), .step_done(step_done),
        .continue_while(continue_while), .ack(ack), .dp_in(dp_in_b),
        .load_x(load_x_b), .load_dx(load_dx_b), .load_a(load_a_b), .load_u(load_u_b),
        .state(state_b), .busy(busy_b), .done(done_b), .iter_count(iter_count_b),
        .iter_limit(iter_limit_b), .step_err(step_err_b)
    );

    assign strobes_a = {load_u_a, load_a_a, load_dx_a, load_x_a};
    assign strobes_b = {load_u_b, load_a_b, load_dx_b, load_x_b};
    assign out_a = {dp_in_a, strobes_a, state_a, busy_a, done_a, iter_count_a, iter_limit_a, step_err_a};
    assign out_b = {dp_in_b, strobes_b, state_b, busy_b, done_b, iter_count_b, iter_limit_b, step_err_b};

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 reading operands, 2..5 compute step 1..4, 6 done.
    typedef struct {
        int         phase;
        int         nibbles;   // operands received so far this run
        int         waited;    // cycles already spent in the current compute step
        int         iters;
        logic       lim;
        logic       err;
        logic [3:0] dp;
        int         strobe;    // operand index strobed this cycle, -1 for none
    } model_t;

    model_t ma, mb;

    function automatic model_t model_reset();
        model_t m;
        m.phase = 0; m.nibbles = 0; m.waited = 0; m.iters = 0;
        m.lim = 1'b0; m.err = 1'b0; m.dp = 4'h0; m.strobe = -1;
        return m;
    endfunction

    function automatic model_t model_step(input model_t m, input int max_iter);
        model_t n;
        n = m;
        n.strobe = -1;
        if (abort) begin
            n.phase = 0;
            n.nibbles = 0;
        end else if (m.phase == 0) begin
            if (start) begin
                n.phase = 1; n.nibbles = 0; n.iters = 0; n.lim = 1'b0; n.err = 1'b0;
            end
        end else if (m.phase == 1) begin
            if (m.nibbles == 4) begin
                n.phase = 2; n.waited = 0;
            end else if (in_valid) begin
                n.dp = din; n.strobe = m.nibbles; n.nibbles = m.nibbles + 1;
            end
        end else if (m.phase >= 2 && m.phase <= 5) begin
            if (step_done) begin
                n.waited = 0;
                if (m.phase < 5) begin
                    n.phase = m.phase + 1;
                end else begin
                    n.iters = (m.iters + 1 > max_iter) ? max_iter : m.iters + 1;
                    if (continue_while && n.iters < max_iter) begin
                        n.phase = 2;
                    end else begin
                        if (continue_while) n.lim = 1'b1;
                        n.phase = 6;
                    end
                end
            end else if (m.waited + 1 >= TO) begin
                n.err = 1'b1; n.phase = 6;
            end else begin
                n.waited = m.waited + 1;
            end
        end else if (m.phase == 6) begin
            if (ack) n.phase = 0;
        end else begin
            n.phase = 0;
        end
        return n;
    endfunction

    function automatic logic [19:0] model_out(input model_t m);
        logic [3:0] s;
        s = (m.strobe >= 0) ? 4'(1 << m.strobe) : 4'h0;
        return {m.dp, s, 3'(m.phase), (m.phase != 0), (m.phase == 6),
                5'(m.iters), m.lim, m.err};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ma <= model_reset();
            mb <= model_reset();
        end else begin
            ma <= model_step(ma, MAX_A);
            mb <= model_step(mb, MAX_B);
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // Per-cycle comparison, half a cycle away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            check("cycle_a", int'(out_a), int'(model_out(ma)));
            check("cycle_b", int'(out_b), int'(model_out(mb)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        step_done = 1'b0; ack = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    // Feeds four nibbles (nibble k in nibs[4k+3:4k]) with gap_min..gap_max idle
    // cycles between them; optionally checks strobe order and dp_in literally.
    task automatic load_nibbles(input logic [15:0] nibs, input int gap_min,
                                input int gap_max, input bit lits);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            din = nibs[4*k +: 4];
            tick();
            in_valid = 1'b0;
            if (lits) begin
                check("load_strobe", int'(strobes_a), 1 << k);
                check("load_dp_in", int'(dp_in_a), int'(nibs[4*k +: 4]));
            end
            if (k < 3) begin
                for (int g = 0; g < int'($urandom_range(gap_max, gap_min)); g++) begin
                    din = 4'($urandom);
                    tick();
                    if (lits) check("gap_strobe", int'(strobes_a), 0);
                end
            end
        end
    endtask

    task automatic random_run(input int r);
        int cycles;
        pulse_start();
        load_nibbles(16'($urandom), 0, 2, 1'b0);
        tick();
        cycles = 0;
        while ((done_a == 1'b0) && (busy_a == 1'b1) && (cycles < 600)) begin
            step_done      = ($urandom_range(3, 0) == 0);
            continue_while = ($urandom_range(9, 0) < 8);
            in_valid       = ($urandom_range(1, 0) == 1);
            din            = 4'($urandom);
            abort          = ($urandom_range(149, 0) == 0);
            tick();
            cycles++;
        end
        clear_inputs();
        if (cycles >= 600) begin
            vectors++;
            miscompares++;
            $display("FAIL run_timeout run %0d: got no done after %0d cycles, required done", r, cycles);
        end
        $display("run %0d: state=%0d iter_count=%0d/%0d iter_limit=%0d/%0d step_err=%0d",
                 r, state_a, iter_count_a, iter_count_b, iter_limit_a, iter_limit_b, step_err_a);
        if (done_a) begin
            repeat ($urandom_range(3, 0)) tick();
            pulse_ack();
        end
    endtask

    initial begin
        clear_inputs();
        din = 4'h0;
        continue_while = 1'b0;
        tick();
        checking = 1'b1;
        tick();
        check("reset_out_a", int'(out_a), 0);
        check("reset_out_b", int'(out_b), 0);
        reset_n = 1'b1;
        tick();

        // Normal load: 2,1,9,0 on consecutive cycles.
        pulse_start();
        check("state_read", int'(state_a), 1);
        load_nibbles(16'h0912, 0, 0, 1'b1);
        check("read_after_u", int'(state_a), 1);
        tick();
        check("state_c1", int'(state_a), 2);
        check("c1_strobes", int'(strobes_a), 0);

        // Loop: step_done every 2nd cycle, continue for 3 iterations then stop.
        for (int it = 0; it < 4; it++) begin
            for (int st = 0; st < 4; st++) begin
                check("loop_state", int'(state_a), 2 + st);
                tick();
                step_done = 1'b1;
                continue_while = (it < 3);
                tick();
                step_done = 1'b0;
            end
        end
        check("loop_done", int'(state_a), 6);
        check("loop_iters", int'(iter_count_a), 4);
        check("loop_limit", int'(iter_limit_a), 0);
        check("cap_iters", int'(iter_count_b), 3);
        check("cap_limit", int'(iter_limit_b), 1);
        check("cap_done", int'(done_b), 1);
        $display("loop run: iter_count=%0d cap iter_count=%0d", iter_count_a, iter_count_b);
        pulse_ack();
        check("ack_busy", int'(busy_a), 0);
        check("idle_keeps_iters", int'(iter_count_a), 4);

        // Watchdog: no step_done in COMPUTE_2.
        pulse_start();
        load_nibbles(16'h5A3C, 0, 0, 1'b0);
        tick();
        step_done = 1'b1; tick(); step_done = 1'b0;
        check("wd_in_c2", int'(state_a), 3);
        repeat (7) tick();
        check("wd_cycle8_state", int'(state_a), 3);
        check("wd_cycle8_err", int'(step_err_a), 0);
        tick();
        check("wd_state", int'(state_a), 6);
        check("wd_err", int'(step_err_a), 1);
        $display("watchdog run: state=%0d step_err=%0d", state_a, step_err_a);
        pulse_ack();

        // step_done in the 8th cycle beats the timeout.
        pulse_start();
        load_nibbles(16'h1234, 0, 0, 1'b0);
        tick();
        step_done = 1'b1; tick(); step_done = 1'b0;
        repeat (7) tick();
        step_done = 1'b1; tick(); step_done = 1'b0;
        check("late_done_state", int'(state_a), 4);
        check("late_done_err", int'(step_err_a), 0);

        // Reset pulsed in COMPUTE_3.
        reset_n = 1'b0;
        #1;
        check("async_rst_a", int'(out_a), 0);
        check("async_rst_b", int'(out_b), 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_state", int'(state_a), 0);
        $display("reset run: state=%0d", state_a);

        // Abort after two nibbles, then a fresh run with 3-cycle gaps.
        pulse_start();
        in_valid = 1'b1; din = 4'h6; tick();
        din = 4'h8; tick();
        in_valid = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_state", int'(state_a), 0);
        check("abort_strobes", int'(strobes_a), 0);
        pulse_start();
        load_nibbles(16'h5C37, 3, 3, 1'b1);
        tick();
        check("gap_c1", int'(state_a), 2);

        // in_valid in COMPUTE_1 and start in DONE are ignored.
        in_valid = 1'b1; din = 4'hF; tick(); in_valid = 1'b0;
        check("ign_strobes", int'(strobes_a), 0);
        check("ign_dp_in", int'(dp_in_a), 5);
        for (int st = 0; st < 4; st++) begin
            step_done = 1'b1; continue_while = 1'b0; tick();
        end
        step_done = 1'b0;
        check("ign_done", int'(state_a), 6);
        check("ign_iters", int'(iter_count_a), 1);
        start = 1'b1; tick(); start = 1'b0;
        check("start_in_done", int'(state_a), 6);
        pulse_ack();

        for (int r = 0; r < 40; r++) begin
            random_run(r);
        end

        tick();
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
